// File: rtl/fill_state_seq.sv
// fill_state_seq: walks one channel's state words in memory, turns each
// returned word into a one-hot load strobe, and latches the leading words
// as configuration. Supports a per-word skip mask, abort and a done pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for fill_start; pipeline empty
// ISSUE | one word index per cycle, read strobe unless masked
// DRAIN | all indices issued, waiting for in-flight returns to land
module fill_state_seq #(
   parameter int CH_NUM     = 4,
   parameter int FILL_WORDS = 16,
   parameter int CFG_WORDS  = 6,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1,
   localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
   localparam int IDX_W     = $clog2(FILL_WORDS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fill_start,
   input  logic [CH_W-1:0]               fill_ch,
   input  logic [FILL_WORDS-1:0]         fill_mask,
   input  logic                          fill_abort,
   output logic                          mem_rd,
   output logic [CH_W+IDX_W-1:0]         mem_addr,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [FILL_WORDS-1:0]         load_en,
   output logic [DATA_W-1:0]             load_data,
   output logic                          last_en,
   output logic [CFG_WORDS*DATA_W-1:0]   cfg_words,
   output logic                          fill_busy,
   output logic                          fill_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILL_WORDS - 1);

   state_t                      state;
   state_t                      state_nxt;
   logic [CH_W-1:0]             ch_q;
   logic [FILL_WORDS-1:0]       mask_q;
   logic [IDX_W-1:0]            idx_q;

   // Return pipeline: live marks an issued slot (masked or not) so drain
   // timing and last_en do not depend on the mask; valid marks a real read.
   logic [RD_LATENCY-1:0]       p_live;
   logic [RD_LATENCY-1:0]       p_valid;
   logic [RD_LATENCY-1:0]       p_last;
   logic [IDX_W-1:0]            p_idx [RD_LATENCY];

   logic [CH_W+IDX_W-1:0]       addr_q;
   logic [DATA_W-1:0]           data_q;
   logic [CFG_WORDS*DATA_W-1:0] cfg_q;

   logic                        issue;
   logic                        accept;
   logic                        flush;
   logic                        any_live;
   logic                        out_live;
   logic                        out_valid;
   logic                        out_last;
   logic [IDX_W-1:0]            out_idx;

   assign issue     = (state == S_ISSUE);
   assign accept    = (state == S_IDLE) && fill_start && !fill_abort;
   assign flush     = fill_abort && (state != S_IDLE);
   assign any_live  = |p_live;
   assign out_live  = p_live[RD_LATENCY-1];
   assign out_valid = p_valid[RD_LATENCY-1];
   assign out_last  = p_last[RD_LATENCY-1];
   assign out_idx   = p_idx[RD_LATENCY-1];

   // Next-state, read strobe and completion pulse.
   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      fill_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (fill_start && !fill_abort) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            mem_rd = ~mask_q[idx_q];
            if (fill_abort)              state_nxt = S_IDLE;
            else if (idx_q == LAST_IDX)  state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (fill_abort) begin
               state_nxt = S_IDLE;
            end else if (!any_live) begin
               fill_done = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register, request latch and word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ch_q   <= '0;
         mask_q <= '0;
         idx_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ch_q   <= fill_ch;
            mask_q <= fill_mask;
            idx_q  <= '0;
         end else if (issue) begin
            idx_q  <= idx_q + 1'b1;
         end
      end
   end

   // Pipeline control bits; abort empties it so nothing further lands.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         p_live  <= '0;
         p_valid <= '0;
         p_last  <= '0;
      end else begin
         p_live[0]  <= issue;
         p_valid[0] <= mem_rd;
         p_last[0]  <= issue && (idx_q == LAST_IDX);
         for (int i = 1; i < RD_LATENCY; i++) begin
            p_live[i]  <= p_live[i-1];
            p_valid[i] <= p_valid[i-1];
            p_last[i]  <= p_last[i-1];
         end
      end
   end

   // Pipeline word index; only meaningful alongside its valid bit.
   always_ff @(posedge clk) begin
      p_idx[0] <= idx_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         p_idx[i] <= p_idx[i-1];
      end
   end

   // Held address/data and the config word latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         cfg_q  <= '0;
      end else begin
         if (mem_rd) addr_q <= {ch_q, idx_q};
         if (out_valid) begin
            data_q <= mem_rdata;
            for (int k = 0; k < CFG_WORDS; k++) begin
               if (out_idx == IDX_W'(k)) cfg_q[k*DATA_W +: DATA_W] <= mem_rdata;
            end
         end
      end
   end

   // One-hot load strobe for the word emerging from the pipeline.
   always_comb begin
      load_en = '0;
      if (out_valid) load_en[out_idx] = 1'b1;
   end

   assign last_en   = out_live & out_last;
   assign load_data = out_valid ? mem_rdata : data_q;
   assign mem_addr  = mem_rd ? {ch_q, idx_q} : addr_q;
   assign fill_busy = (state != S_IDLE);
   assign cfg_words = cfg_q;

endmodule

// File: tb/tb_fill_state_seq.sv
// Directed bench for fill_state_seq: a default instance (latency 1, 16 words)
// and a latency-3, 8-word instance share stimulus; sel picks which is checked.
module tb_fill_state_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        fill_start;
   logic [1:0]  fill_ch;
   logic [15:0] fill_mask;
   logic        fill_abort;
   logic        sel;
   logic [31:0] base;

   logic        a_mem_rd, a_last, a_busy, a_done;
   logic [5:0]  a_addr;
   logic [31:0] a_rdata, a_load_data;
   logic [15:0] a_load_en;
   logic [191:0] a_cfg;

   logic        b_mem_rd, b_last, b_busy, b_done;
   logic [4:0]  b_addr;
   logic [31:0] b_rdata, b_load_data, b_s0, b_s1;
   logic [7:0]  b_load_en;
   logic [63:0] b_cfg;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cur_rel = 0;
   logic [31:0] exp_addr;
   logic [31:0] exp_data;
   logic [31:0] exp_cfg [6];

   always #5 clk = ~clk;

   fill_state_seq dut_a (
      .clk(clk), .rst(rst), .fill_start(fill_start), .fill_ch(fill_ch),
      .fill_mask(fill_mask), .fill_abort(fill_abort), .mem_rd(a_mem_rd),
      .mem_addr(a_addr), .mem_rdata(a_rdata), .load_en(a_load_en),
      .load_data(a_load_data), .last_en(a_last), .cfg_words(a_cfg),
      .fill_busy(a_busy), .fill_done(a_done)
   );

   fill_state_seq #(.CH_NUM(4), .FILL_WORDS(8), .CFG_WORDS(2), .DATA_W(32), .RD_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .fill_start(fill_start), .fill_ch(fill_ch),
      .fill_mask(fill_mask[7:0]), .fill_abort(fill_abort), .mem_rd(b_mem_rd),
      .mem_addr(b_addr), .mem_rdata(b_rdata), .load_en(b_load_en),
      .load_data(b_load_data), .last_en(b_last), .cfg_words(b_cfg),
      .fill_busy(b_busy), .fill_done(b_done)
   );

   // Memory models: word k of any channel reads back as base + k.
   always @(posedge clk) begin
      a_rdata <= a_mem_rd ? base + 32'(a_addr[3:0]) : 32'hDEAD_BEEF;
      b_s0    <= b_mem_rd ? base + 32'(b_addr[2:0]) : 32'hDEAD_BEEF;
      b_s1    <= b_s0;
      b_rdata <= b_s1;
   end

   logic        o_mem_rd, o_last, o_busy, o_done;
   logic [31:0] o_addr, o_load_data;
   logic [15:0] o_load_en;

   assign o_mem_rd    = sel ? b_mem_rd : a_mem_rd;
   assign o_last      = sel ? b_last   : a_last;
   assign o_busy      = sel ? b_busy   : a_busy;
   assign o_done      = sel ? b_done   : a_done;
   assign o_addr      = sel ? 32'(b_addr) : 32'(a_addr);
   assign o_load_data = sel ? b_load_data : a_load_data;
   assign o_load_en   = sel ? {8'h00, b_load_en} : a_load_en;

   function automatic logic [31:0] obs_cfg(input int k);
      if (sel) return b_cfg[k*32 +: 32];
      return a_cfg[k*32 +: 32];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s rel=%0d got=%0h exp=%0h", tag, cur_rel, got, exp);
      end
   endtask

   task automatic clear_exp();
      exp_addr = '0;
      exp_data = '0;
      for (int k = 0; k < 6; k++) exp_cfg[k] = '0;
   endtask

   // One fill: start at rel 0, optional abort and extra (ignored) start.
   task automatic run_fill(input int f, input int l, input int c, input logic [1:0] ch,
                           input logic [15:0] mask, input int abort_at, input int extra_at,
                           input int ncyc);
      int          idx;
      logic        cut, e_rd, e_ld, e_last, e_done, e_busy;
      logic [15:0] e_len;
      for (int rel = 0; rel < ncyc; rel++) begin
         @(negedge clk);
         cur_rel    = rel;
         fill_start = (rel == 0) || (rel == extra_at);
         fill_abort = (rel == abort_at);
         fill_ch    = (rel == 0) ? ch : ~ch;
         fill_mask  = (rel == 0) ? mask : ~mask;
         #1;
         cut  = (abort_at >= 0) && (rel > abort_at);
         e_rd = 1'b0;
         if (!cut && rel >= 1 && rel <= f) e_rd = ~mask[rel-1];
         chk("mem_rd", o_mem_rd, e_rd);
         if (e_rd) exp_addr = 32'(ch) * 32'(f) + 32'(rel - 1);
         chk("mem_addr", o_addr, exp_addr);
         idx  = rel - 1 - l;
         e_ld = 1'b0;
         if (!cut && idx >= 0 && idx < f) e_ld = ~mask[idx];
         e_len = e_ld ? (16'd1 << idx) : 16'd0;
         chk("load_en", o_load_en, e_len);
         if (e_ld) exp_data = base + 32'(idx);
         chk("load_data", o_load_data, exp_data);
         if (e_ld && idx < c) exp_cfg[idx] = base + 32'(idx);
         e_last = !cut && (rel == f + l);
         e_done = (rel == f + l + 1) && !((abort_at >= 0) && (rel >= abort_at));
         e_busy = !cut && (rel >= 1) && (rel <= f + l + 1);
         chk("last_en", o_last, e_last);
         chk("fill_done", o_done, e_done);
         chk("fill_busy", o_busy, e_busy);
      end
      fill_start = 1'b0;
      fill_abort = 1'b0;
      for (int k = 0; k < c; k++) chk("cfg_word", obs_cfg(k), exp_cfg[k]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog rel=%0d got=timeout exp=finish", cur_rel);
      $fatal(1, "watchdog");
   end

   initial begin
      sel        = 1'b0;
      base       = 32'h0;
      rst        = 1'b1;
      fill_start = 1'b0;
      fill_abort = 1'b0;
      fill_ch    = 2'd0;
      fill_mask  = 16'h0;
      clear_exp();

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_rd", o_mem_rd, 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_load_en", o_load_en, 0);
      chk("rst_load_data", o_load_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_cfg", a_cfg[63:0], 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic fill, channel 2, no mask
      base = 32'hA000_0000;
      run_fill(16, 1, 6, 2'd2, 16'h0000, -1, -1, 20);

      // Masked words 2 and 5 keep their previous config value
      base = 32'hB000_0000;
      run_fill(16, 1, 6, 2'd1, 16'h0024, -1, -1, 20);

      // Abort at rel 5: words 0..3 land, nothing after
      base = 32'hC000_0000;
      run_fill(16, 1, 6, 2'd3, 16'h0000, 5, -1, 10);

      // Start and abort together in IDLE: no fill
      @(negedge clk);
      fill_start = 1'b1;
      fill_abort = 1'b1;
      @(negedge clk);
      fill_start = 1'b0;
      fill_abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sa_busy", o_busy, 0);
         chk("sa_mem_rd", o_mem_rd, 0);
         @(negedge clk);
      end

      // Start during ISSUE ignored; first and last words masked
      base = 32'hD000_0000;
      run_fill(16, 1, 6, 2'd0, 16'h8001, -1, 5, 20);

      // Reset in the middle of a fill clears everything
      @(negedge clk);
      fill_start = 1'b1;
      fill_ch    = 2'd2;
      fill_mask  = 16'h0;
      @(negedge clk);
      fill_start = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      chk("pre_rst_busy", o_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_mem_rd", o_mem_rd, 0);
      chk("mid_rst_addr", o_addr, 0);
      chk("mid_rst_load_en", o_load_en, 0);
      chk("mid_rst_load_data", o_load_data, 0);
      chk("mid_rst_last", o_last, 0);
      chk("mid_rst_done", o_done, 0);
      for (int k = 0; k < 6; k++) chk("mid_rst_cfg", obs_cfg(k), 0);
      clear_exp();
      repeat (2) @(negedge clk);

      // Latency 3, 8 words: start in the done cycle ignored, next cycle accepted
      sel  = 1'b1;
      base = 32'hE000_0000;
      run_fill(8, 3, 2, 2'd1, 16'h0000, -1, 12, 13);
      base = 32'hF000_0000;
      run_fill(8, 3, 2, 2'd3, 16'h0081, -1, -1, 14);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
